// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-bank write arbiter.
package regfile_arb_pkg;

    localparam int ARB_DATA_W  = 64;
    localparam int ARB_REG_NUM = 32;
    localparam int ARB_RW      = $clog2(ARB_REG_NUM);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        DRAIN   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ARB_RW-1:0]     rd;
        logic [ARB_DATA_W-1:0] data;
    } gpu_wr_entry_t;

    localparam logic [1:0] GNT_IDLE = 2'd0;
    localparam logic [1:0] GNT_CPU  = 2'd1;
    localparam logic [1:0] GNT_GPU  = 2'd2;

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// GPU write queue: circular buffer with occupancy, registered ready, and a
// per-entry address-match vector plus youngest-match data for read checks.
module gpu_wr_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  gpu_wr_entry_t         push_entry_i,
    input  logic                  pop_i,
    input  logic [ARB_RW-1:0]     rd_addr_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  empty_o,
    output logic                  ready_o,
    output gpu_wr_entry_t         head_o,
    output logic [DEPTH-1:0]      match_o,
    output logic [ARB_DATA_W-1:0] hit_data_o
);

    gpu_wr_entry_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push_s, do_pop_s;

    // A full queue refuses pushes even when it is popped in the same cycle.
    assign do_push_s = push_i & ready_q;
    assign do_pop_s  = pop_i & (count_q != '0);

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push_s);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop_s);
        count_d  = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        ready_d  = (count_d != CNT_W'(DEPTH));
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage; stale contents are masked by occupancy.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Live-entry address match, indexed by physical slot.
    always_comb begin
        match_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q) &&
                         (mem_q[i].rd == rd_addr_i) && (rd_addr_i != '0);
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_data_o = match_o[rd_ptr_q + PTR_W'(k)] ?
                         mem_q[rd_ptr_q + PTR_W'(k)].data : hit_data_o;
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign ready_o = ready_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-bank write port between CPU writeback and queued GPU writes.
// Optional REGFILE_ARB_FORWARD_EN: GPU reads that hit the queue return the youngest queued data.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = ARB_DATA_W,
    parameter int REG_NUM      = ARB_REG_NUM,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int RW = $clog2(REG_NUM),
    localparam int PW = $clog2(FIFO_DEPTH + 1),
    localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_w_en,
    input  logic [RW-1:0]         wb_rd,
    input  logic [ADDR_WIDTH-1:0] w_result,
    input  logic                  gpu_w_valid,
    output logic                  gpu_w_ready,
    input  logic [RW-1:0]         gpu_w_rd,
    input  logic [ADDR_WIDTH-1:0] gpu_w_data,
    input  logic                  gpu_r_valid,
    input  logic [RW-1:0]         gpu_r_addr,
    output logic                  gpu_r_ready,
    output logic [ADDR_WIDTH-1:0] gpu_r_data,
    output logic                  rf_w_en,
    output logic [RW-1:0]         rf_w_addr,
    output logic [ADDR_WIDTH-1:0] rf_w_data,
    output logic [RW-1:0]         rf_rs_gpu,
    input  logic [ADDR_WIDTH-1:0] rf_read_gpu,
    output logic                  cpu_stall,
    output logic [PW-1:0]         gpu_pending
);

`ifdef REGFILE_ARB_FORWARD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    arb_state_t              state_q, state_d;
    logic [SW-1:0]           starve_q, starve_d;
    logic                    cpu_stall_q;
    logic [1:0]              gnt_src_s;
    logic                    push_s, pop_s, hit_s;
    logic                    fifo_empty_s, fifo_ready_s;
    logic [PW-1:0]           fifo_count_s, count_next_s;
    logic [FIFO_DEPTH-1:0]   match_s;
    logic [ADDR_WIDTH-1:0]   hit_data_s;
    gpu_wr_entry_t           head_s;
    gpu_wr_entry_t           push_entry_s;

    // Writes to rd 0 are acknowledged but never queued.
    assign push_s       = gpu_w_valid & fifo_ready_s & (gpu_w_rd != '0);
    assign pop_s        = (gnt_src_s == GNT_GPU);
    assign count_next_s = fifo_count_s + PW'(push_s) - PW'(pop_s);
    assign push_entry_s = '{rd: gpu_w_rd, data: gpu_w_data};
    assign hit_s        = |match_s;

    gpu_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .rd_addr_i    (gpu_r_addr),
        .count_o      (fifo_count_s),
        .empty_o      (fifo_empty_s),
        .ready_o      (fifo_ready_s),
        .head_o       (head_s),
        .match_o      (match_s),
        .hit_data_o   (hit_data_s)
    );

    // Port grant: a real CPU write always wins, so writeback never loses data.
    always_comb begin
        if (wb_w_en && (wb_rd != '0)) begin
            gnt_src_s = GNT_CPU;
        end else if (!fifo_empty_s) begin
            gnt_src_s = GNT_GPU;
        end else begin
            gnt_src_s = GNT_IDLE;
        end
    end

    // Bank write mux.
    always_comb begin
        rf_w_en   = 1'b0;
        rf_w_addr = '0;
        rf_w_data = '0;
        case (gnt_src_s)
            GNT_CPU: begin
                rf_w_en   = !reset;
                rf_w_addr = wb_rd;
                rf_w_data = w_result;
            end
            GNT_GPU: begin
                rf_w_en   = !reset;
                rf_w_addr = head_s.rd;
                rf_w_data = head_s.data;
            end
            default: begin
                rf_w_en   = 1'b0;
            end
        endcase
    end

    // Starvation count and drain FSM next state.
    always_comb begin
        if (fifo_empty_s || (gnt_src_s == GNT_GPU)) begin
            starve_d = '0;
        end else if ((gnt_src_s == GNT_CPU) && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = push_s ? PENDING : EMPTY;
            PENDING: begin
                if (count_next_s == '0) begin
                    state_d = EMPTY;
                end else if (starve_d == SW'(STARVE_LIMIT)) begin
                    state_d = DRAIN;
                end else begin
                    state_d = PENDING;
                end
            end
            DRAIN:   state_d = (count_next_s == '0) ? EMPTY : DRAIN;
            default: state_d = EMPTY;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            starve_q    <= '0;
            cpu_stall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cpu_stall_q <= (state_d == DRAIN);
        end
    end

    // GPU read: a queued write to the same register makes the bank value stale.
    always_comb begin
        if (hit_s && FWD_EN) begin
            gpu_r_ready = gpu_r_valid & !reset;
            gpu_r_data  = hit_data_s;
        end else begin
            gpu_r_ready = gpu_r_valid & !reset & !hit_s;
            gpu_r_data  = rf_read_gpu;
        end
    end

    assign rf_rs_gpu   = gpu_r_addr;
    assign cpu_stall   = cpu_stall_q;
    assign gpu_w_ready = fifo_ready_s;
    assign gpu_pending = fifo_count_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

    localparam int DW = 64;
    localparam int RW = 5;
    localparam int PW = 3;

    logic          clk;
    logic          reset;
    logic          wb_w_en;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] w_result;
    logic          gpu_w_valid;
    logic          gpu_w_ready;
    logic [RW-1:0] gpu_w_rd;
    logic [DW-1:0] gpu_w_data;
    logic          gpu_r_valid;
    logic [RW-1:0] gpu_r_addr;
    logic          gpu_r_ready;
    logic [DW-1:0] gpu_r_data;
    logic          rf_w_en;
    logic [RW-1:0] rf_w_addr;
    logic [DW-1:0] rf_w_data;
    logic [RW-1:0] rf_rs_gpu;
    logic [DW-1:0] rf_read_gpu;
    logic          cpu_stall;
    logic [PW-1:0] gpu_pending;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic zero_seen = 1'b0;

    regfile_write_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .wb_w_en     (wb_w_en),
        .wb_rd       (wb_rd),
        .w_result    (w_result),
        .gpu_w_valid (gpu_w_valid),
        .gpu_w_ready (gpu_w_ready),
        .gpu_w_rd    (gpu_w_rd),
        .gpu_w_data  (gpu_w_data),
        .gpu_r_valid (gpu_r_valid),
        .gpu_r_addr  (gpu_r_addr),
        .gpu_r_ready (gpu_r_ready),
        .gpu_r_data  (gpu_r_data),
        .rf_w_en     (rf_w_en),
        .rf_w_addr   (rf_w_addr),
        .rf_w_data   (rf_w_data),
        .rf_rs_gpu   (rf_rs_gpu),
        .rf_read_gpu (rf_read_gpu),
        .cpu_stall   (cpu_stall),
        .gpu_pending (gpu_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_w_en && (rf_w_addr == '0)) zero_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [RW-1:0] q_rd   [4];
    logic [DW-1:0] q_data [4];

    initial begin
        q_rd[0] = 5'd3;  q_data[0] = 64'h99;
        q_rd[1] = 5'd10; q_data[1] = 64'h101;
        q_rd[2] = 5'd3;  q_data[2] = 64'h77;
        q_rd[3] = 5'd12; q_data[3] = 64'h103;

        reset = 1'b1; wb_w_en = 1'b0; wb_rd = '0; w_result = '0;
        gpu_w_valid = 1'b0; gpu_w_rd = '0; gpu_w_data = '0;
        gpu_r_valid = 1'b1; gpu_r_addr = 5'd1; rf_read_gpu = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_rf_w_en", rf_w_en, 64'd0);
        check_eq("rst_cpu_stall", cpu_stall, 64'd0);
        check_eq("rst_pending", gpu_pending, 64'd0);
        check_eq("rst_w_ready", gpu_w_ready, 64'd1);
        check_eq("rst_r_ready", gpu_r_ready, 64'd0);
        next_cycle();
        reset = 1'b0; gpu_r_valid = 1'b0;

        // CPU only
        wb_w_en = 1'b1; wb_rd = 5'd5; w_result = 64'hAA;
        @(negedge clk);
        check_eq("cpu_w_en", rf_w_en, 64'd1);
        check_eq("cpu_w_addr", rf_w_addr, 64'd5);
        check_eq("cpu_w_data", rf_w_data, 64'hAA);
        check_eq("cpu_pending", gpu_pending, 64'd0);
        next_cycle();
        wb_rd = 5'd0;
        @(negedge clk);
        check_eq("cpu_rd0_no_write", rf_w_en, 64'd0);
        next_cycle();

        // GPU only
        wb_w_en = 1'b0;
        gpu_w_valid = 1'b1; gpu_w_rd = 5'd7; gpu_w_data = 64'h55;
        @(negedge clk);
        check_eq("gpu_same_cycle_no_write", rf_w_en, 64'd0);
        next_cycle();
        gpu_w_valid = 1'b0;
        @(negedge clk);
        check_eq("gpu_pending_1", gpu_pending, 64'd1);
        check_eq("gpu_w_en", rf_w_en, 64'd1);
        check_eq("gpu_w_addr", rf_w_addr, 64'd7);
        check_eq("gpu_w_data", rf_w_data, 64'h55);
        next_cycle();
        @(negedge clk);
        check_eq("gpu_pending_0", gpu_pending, 64'd0);
        check_eq("gpu_idle", rf_w_en, 64'd0);
        next_cycle();
        gpu_w_valid = 1'b1; gpu_w_rd = 5'd0; gpu_w_data = 64'h12;
        next_cycle();
        gpu_w_valid = 1'b0;
        @(negedge clk);
        check_eq("gpu_rd0_discard_pending", gpu_pending, 64'd0);
        check_eq("gpu_rd0_discard_write", rf_w_en, 64'd0);
        next_cycle();

        // Fill the queue while the CPU holds the port
        wb_w_en = 1'b1; wb_rd = 5'd9;
        for (int i = 0; i < 4; i++) begin
            w_result = 64'h900 + 64'(i);
            gpu_w_valid = 1'b1; gpu_w_rd = q_rd[i]; gpu_w_data = q_data[i];
            @(negedge clk);
            check_eq("fill_cpu_addr", rf_w_addr, 64'd9);
            check_eq("fill_w_ready", gpu_w_ready, 64'd1);
            next_cycle();
        end
        gpu_w_rd = 5'd14; gpu_w_data = 64'h140;
        @(negedge clk);
        check_eq("full_w_ready", gpu_w_ready, 64'd0);
        check_eq("full_pending", gpu_pending, 64'd4);
        next_cycle();
        gpu_w_valid = 1'b0;
        gpu_r_valid = 1'b1; gpu_r_addr = 5'd3; rf_read_gpu = 64'h5A5A;
        @(negedge clk);
        check_eq("fifth_rejected", gpu_pending, 64'd4);
        check_eq("rs_gpu", rf_rs_gpu, 64'd3);
`ifdef REGFILE_ARB_FORWARD_EN
        check_eq("read_hit_ready", gpu_r_ready, 64'd1);
        check_eq("read_hit_fwd_data", gpu_r_data, 64'h77);
`else
        check_eq("read_hit_ready", gpu_r_ready, 64'd0);
`endif
        next_cycle();
        gpu_r_addr = 5'd20; rf_read_gpu = 64'hDEAD;
        @(negedge clk);
        check_eq("read_miss_ready", gpu_r_ready, 64'd1);
        check_eq("read_miss_data", gpu_r_data, 64'hDEAD);
        next_cycle();
        gpu_r_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check_eq("starve_no_stall_c8", cpu_stall, 64'd0);
        next_cycle();
        w_result = 64'h9C9;
        @(negedge clk);
        check_eq("starve_stall_c9", cpu_stall, 64'd1);
        check_eq("drain_cpu_wins_addr", rf_w_addr, 64'd9);
        check_eq("drain_cpu_wins_data", rf_w_data, 64'h9C9);
        next_cycle();
        wb_w_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check_eq("drain_w_en", rf_w_en, 64'd1);
            check_eq("drain_addr", rf_w_addr, 64'(q_rd[j]));
            check_eq("drain_data", rf_w_data, q_data[j]);
            check_eq("drain_stall_held", cpu_stall, 64'd1);
            next_cycle();
        end
        @(negedge clk);
        check_eq("drain_done_stall", cpu_stall, 64'd0);
        check_eq("drain_done_pending", gpu_pending, 64'd0);
        check_eq("drain_done_idle", rf_w_en, 64'd0);
        next_cycle();

        // Reset in the middle of a forced drain
        wb_w_en = 1'b1; wb_rd = 5'd9;
        for (int k = 0; k < 9; k++) begin
            gpu_w_valid = (k < 2);
            gpu_w_rd = (k == 0) ? 5'd4 : 5'd6;
            gpu_w_data = (k == 0) ? 64'h44 : 64'h66;
            next_cycle();
        end
        @(negedge clk);
        check_eq("pre_reset_stall", cpu_stall, 64'd1);
        check_eq("pre_reset_pending", gpu_pending, 64'd2);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; wb_w_en = 1'b0;
        @(negedge clk);
        check_eq("post_reset_pending", gpu_pending, 64'd0);
        check_eq("post_reset_stall", cpu_stall, 64'd0);
        check_eq("post_reset_w_en", rf_w_en, 64'd0);
        check_eq("post_reset_w_ready", gpu_w_ready, 64'd1);
        next_cycle();
        @(negedge clk);
        check_eq("post_reset_flushed", rf_w_en, 64'd0);
        next_cycle();

        check_eq("no_rd0_write", zero_seen, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
